// File: rtl/udp_rx_pingpong_ctrl_if.sv
// Signal bundle between the UDP receiver, the two-bank payload RAM, the
// frame consumer and the ping-pong controller.
interface udp_rx_pingpong_ctrl_if #(
  parameter int BANK_AW = 8
);
  logic               rx_sof;
  logic [31:0]        rx_data;
  logic               rx_valid;
  logic               rx_eof;
  logic [15:0]        rx_len;

  logic               ram_we;
  logic [BANK_AW:0]   ram_waddr;
  logic [31:0]        ram_wdata;
  logic [BANK_AW:0]   ram_raddr;
  logic [31:0]        ram_rdata;

  logic               frm_avail;
  logic [15:0]        frm_bytes;
  logic [BANK_AW:0]   frm_words;
  logic               frm_trunc;
  logic               rd_start;

  logic [31:0]        out_data;
  logic               out_valid;
  logic               out_last;
  logic [15:0]        drop_cnt;
  logic               busy;

  modport master (
    output rx_sof, rx_data, rx_valid, rx_eof, rx_len, ram_rdata, rd_start,
    input  ram_we, ram_waddr, ram_wdata, ram_raddr,
    input  frm_avail, frm_bytes, frm_words, frm_trunc,
    input  out_data, out_valid, out_last, drop_cnt, busy
  );

  modport slave (
    input  rx_sof, rx_data, rx_valid, rx_eof, rx_len, ram_rdata, rd_start,
    output ram_we, ram_waddr, ram_wdata, ram_raddr,
    output frm_avail, frm_bytes, frm_words, frm_trunc,
    output out_data, out_valid, out_last, drop_cnt, busy
  );
endinterface

// File: rtl/udp_rx_pingpong_ctrl.sv
// Ping-pong buffer controller: fills two RAM banks with UDP payloads and
// streams committed frames out in arrival order.
//
// state   | meaning
// W_IDLE  | waiting for rx_sof
// W_FILL  | writing payload words into bank[wr_ptr]
// W_DROP  | no free bank, discarding until rx_eof
// R_IDLE  | waiting for rd_start on a FULL head bank
// R_READ  | issuing read addresses for the head frame
// R_FLUSH | last word on the output, bank released at this edge
module udp_rx_pingpong_ctrl #(
  parameter int BANK_AW   = 8,
  parameter int HDR_BYTES = 8
) (
  input logic                   i_clk,
  input logic                   i_clr,
  udp_rx_pingpong_ctrl_if.slave io_bus
);

  localparam logic [BANK_AW:0] DEPTH = {1'b1, {BANK_AW{1'b0}}};
  localparam logic [15:0]      HDR   = 16'(HDR_BYTES);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_FLUSH} rd_state_t;
  typedef enum logic [1:0] {B_FREE, B_FULL, B_READING} bank_state_t;

  wr_state_t        r_wr_state, w_wr_next;
  rd_state_t        r_rd_state, w_rd_next;
  bank_state_t      r_bank [2];

  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [BANK_AW:0] r_wr_off;
  logic             r_trunc;
  logic [BANK_AW:0] r_meta_words [2];
  logic [15:0]      r_meta_bytes [2];
  logic             r_meta_trunc [2];

  logic             r_we;
  logic [BANK_AW:0] r_waddr;
  logic [31:0]      r_wdata;
  logic [15:0]      r_drop_cnt;

  logic [BANK_AW:0] r_raddr;
  logic [BANK_AW:0] r_rd_left;
  logic             r_out_valid;

  logic             w_start, w_drop, w_eof;
  logic             w_bank_free, w_in_fill, w_wr_word, w_ovf_word, w_commit;
  logic             w_trunc_nxt;
  logic [BANK_AW:0] w_off_base, w_off_nxt;
  logic [15:0]      w_bytes;

  logic             w_frm_avail, w_rd_go, w_rd_done;
  logic [BANK_AW-1:0] w_rd_off_inc;

  // A bank being released this edge still reads READING, so a colliding rx_sof drops
  assign w_bank_free = (r_bank[r_wr_ptr] == B_FREE);

  always_comb begin
    w_wr_next = r_wr_state;
    w_start   = 1'b0;
    w_drop    = 1'b0;
    w_eof     = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        if (io_bus.rx_sof) begin
          if (w_bank_free) begin
            w_start   = 1'b1;
            w_wr_next = W_FILL;
          end else begin
            w_drop    = 1'b1;
            w_wr_next = W_DROP;
          end
        end
      end
      W_FILL: begin
        if (io_bus.rx_eof) begin
          w_eof     = 1'b1;
          w_wr_next = W_IDLE;
        end else if (io_bus.rx_sof) begin
          w_start   = 1'b1;
        end
      end
      W_DROP: begin
        if (io_bus.rx_eof) begin
          w_wr_next = W_IDLE;
        end else if (io_bus.rx_sof) begin
          w_drop    = 1'b1;
        end
      end
      default: w_wr_next = W_IDLE;
    endcase
  end

  // Restarted fills (new or aborted frame) count from offset 0 in the same cycle
  assign w_in_fill   = w_start || (r_wr_state == W_FILL);
  assign w_off_base  = w_start ? '0 : r_wr_off;
  assign w_wr_word   = w_in_fill && io_bus.rx_valid && (w_off_base < DEPTH);
  assign w_ovf_word  = w_in_fill && io_bus.rx_valid && !(w_off_base < DEPTH);
  assign w_off_nxt   = w_off_base + {{BANK_AW{1'b0}}, w_wr_word};
  assign w_trunc_nxt = (r_trunc && !w_start) || w_ovf_word;
  assign w_commit    = w_eof && (w_off_nxt != '0);
  assign w_bytes     = (io_bus.rx_len < HDR) ? 16'd0 : (io_bus.rx_len - HDR);

  always_ff @(posedge i_clk or negedge i_clr) begin
    if (!i_clr) begin
      r_wr_state <= W_IDLE;
      r_wr_ptr   <= 1'b0;
      r_wr_off   <= '0;
      r_trunc    <= 1'b0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_wr_state <= w_wr_next;
      r_we       <= w_wr_word;
      if (w_wr_word) begin
        r_waddr <= {r_wr_ptr, w_off_base[BANK_AW-1:0]};
        r_wdata <= io_bus.rx_data;
      end
      if (w_in_fill) begin
        r_wr_off <= w_off_nxt;
        r_trunc  <= w_trunc_nxt;
      end
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      if (w_commit) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
    end
  end

  assign w_frm_avail = (r_rd_state == R_IDLE) && (r_bank[r_rd_ptr] == B_FULL);

  always_comb begin
    w_rd_next = r_rd_state;
    w_rd_go   = 1'b0;
    w_rd_done = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        if (io_bus.rd_start && w_frm_avail) begin
          w_rd_go   = 1'b1;
          w_rd_next = R_READ;
        end
      end
      R_READ: begin
        if (r_rd_left == '0) begin
          w_rd_next = R_FLUSH;
        end
      end
      R_FLUSH: begin
        w_rd_done = 1'b1;
        w_rd_next = R_IDLE;
      end
      default: w_rd_next = R_IDLE;
    endcase
  end

  assign w_rd_off_inc = r_raddr[BANK_AW-1:0] + BANK_AW'(1);

  // r_rd_left counts down the addresses still to issue; zero marks the last one
  always_ff @(posedge i_clk or negedge i_clr) begin
    if (!i_clr) begin
      r_rd_state  <= R_IDLE;
      r_rd_ptr    <= 1'b0;
      r_raddr     <= '0;
      r_rd_left   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_rd_state  <= w_rd_next;
      r_out_valid <= (r_rd_state == R_READ);
      if (w_rd_go) begin
        r_raddr   <= {r_rd_ptr, {BANK_AW{1'b0}}};
        r_rd_left <= r_meta_words[r_rd_ptr] - (BANK_AW+1)'(1);
      end else if ((r_rd_state == R_READ) && (r_rd_left != '0)) begin
        r_raddr   <= {r_rd_ptr, w_rd_off_inc};
        r_rd_left <= r_rd_left - (BANK_AW+1)'(1);
      end
      if (w_rd_done) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

  // Commit and release always target different banks, so both can land together
  always_ff @(posedge i_clk or negedge i_clr) begin
    if (!i_clr) begin
      for (int b = 0; b < 2; b++) begin
        r_bank[b]       <= B_FREE;
        r_meta_words[b] <= '0;
        r_meta_bytes[b] <= '0;
        r_meta_trunc[b] <= 1'b0;
      end
    end else begin
      if (w_commit) begin
        r_bank[r_wr_ptr]       <= B_FULL;
        r_meta_words[r_wr_ptr] <= w_off_nxt;
        r_meta_bytes[r_wr_ptr] <= w_bytes;
        r_meta_trunc[r_wr_ptr] <= w_trunc_nxt;
      end
      if (w_rd_go) begin
        r_bank[r_rd_ptr] <= B_READING;
      end
      if (w_rd_done) begin
        r_bank[r_rd_ptr] <= B_FREE;
      end
    end
  end

  assign io_bus.ram_we    = r_we;
  assign io_bus.ram_waddr = r_waddr;
  assign io_bus.ram_wdata = r_wdata;
  assign io_bus.ram_raddr = r_raddr;

  assign io_bus.frm_avail = w_frm_avail;
  assign io_bus.frm_bytes = w_frm_avail ? r_meta_bytes[r_rd_ptr] : 16'd0;
  assign io_bus.frm_words = w_frm_avail ? r_meta_words[r_rd_ptr] : '0;
  assign io_bus.frm_trunc = w_frm_avail && r_meta_trunc[r_rd_ptr];

  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_data  = r_out_valid ? io_bus.ram_rdata : 32'd0;
  assign io_bus.out_last  = (r_rd_state == R_FLUSH);
  assign io_bus.drop_cnt  = r_drop_cnt;
  assign io_bus.busy      = (r_wr_state != W_IDLE) || (r_rd_state != R_IDLE);

endmodule

// File: tb/tb_udp_rx_pingpong_ctrl.sv
// Scoreboard bench for udp_rx_pingpong_ctrl: stimulus queues expected RAM
// writes and streamed words, a negedge monitor pops and compares them.
module tb_udp_rx_pingpong_ctrl;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  udp_rx_pingpong_ctrl_if #(.BANK_AW(AW)) bus ();

  udp_rx_pingpong_ctrl #(.BANK_AW(AW), .HDR_BYTES(8)) dut (
    .i_clk (clk),
    .i_clr (clr),
    .io_bus(bus)
  );

  logic [31:0] mem [0:511];
  initial for (int i = 0; i < 512; i++) mem[i] = 32'd0;
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_raddr];
  end

  typedef struct packed { logic [AW:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic [31:0] data; logic last; } rd_t;
  wr_t exp_wr [$];
  rd_t exp_rd [$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t ew;
    rd_t er;
    if (bus.ram_we === 1'b1) begin
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_unexpected actual addr=%0h data=%0h required no write", bus.ram_waddr, bus.ram_wdata);
      end else begin
        ew = exp_wr.pop_front();
        chk("wr_addr", 64'(bus.ram_waddr), 64'(ew.addr));
        chk("wr_data", 64'(bus.ram_wdata), 64'(ew.data));
      end
    end
    if (bus.out_valid === 1'b1) begin
      if (exp_rd.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_unexpected actual data=%0h required no output", bus.out_data);
      end else begin
        er = exp_rd.pop_front();
        chk("out_data", 64'(bus.out_data), 64'(er.data));
        chk("out_last", 64'(bus.out_last), 64'(er.last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wr"},   {bus.ram_we, bus.ram_waddr, bus.ram_wdata}, 64'd0);
    chk({tag, "_raddr"}, 64'(bus.ram_raddr), 64'd0);
    chk({tag, "_frm"},  {bus.frm_avail, bus.frm_bytes, bus.frm_words, bus.frm_trunc}, 64'd0);
    chk({tag, "_out"},  {bus.out_data, bus.out_valid, bus.out_last}, 64'd0);
    chk({tag, "_drop"}, 64'(bus.drop_cnt), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic do_reset();
    bus.rx_sof = 1'b0; bus.rx_valid = 1'b0; bus.rx_eof = 1'b0;
    bus.rx_data = 32'd0; bus.rx_len = 16'd0; bus.rd_start = 1'b0;
    clr = 1'b0;
    #1;
    check_zero("rst");
    tick();
    tick();
    clr = 1'b1;
    tick();
  endtask

  task automatic sof();
    bus.rx_sof = 1'b1;
    tick();
    bus.rx_sof = 1'b0;
  endtask

  task automatic word(input logic [31:0] d, input logic eof, input logic [15:0] len,
                      input logic wr_exp, input logic [AW:0] addr);
    wr_t e;
    bus.rx_valid = 1'b1; bus.rx_data = d; bus.rx_eof = eof; bus.rx_len = len;
    if (wr_exp) begin
      e.addr = addr; e.data = d;
      exp_wr.push_back(e);
    end
    tick();
    bus.rx_valid = 1'b0; bus.rx_eof = 1'b0; bus.rx_data = 32'd0;
  endtask

  task automatic expect_out(input logic [31:0] d, input logic last);
    rd_t e;
    e.data = d; e.last = last;
    exp_rd.push_back(e);
  endtask

  task automatic rd_frame(input int n);
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    chk("rd_lat_t1", 64'(bus.out_valid), 64'd0);
    tick();
    chk("rd_lat_t2", 64'(bus.out_valid), 64'd1);
    repeat (n + 1) tick();
  endtask

  task automatic chk_frm(input string tag, input logic [15:0] by, input logic [AW:0] wd, input logic tr);
    chk({tag, "_avail"}, 64'(bus.frm_avail), 64'd1);
    chk({tag, "_bytes"}, 64'(bus.frm_bytes), 64'(by));
    chk({tag, "_words"}, 64'(bus.frm_words), 64'(wd));
    chk({tag, "_trunc"}, 64'(bus.frm_trunc), 64'(tr));
  endtask

  task automatic chk_q(input string tag);
    chk({tag, "_queues_empty"}, 64'(exp_wr.size() + exp_rd.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=still running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // single frame
    sof();
    chk("t1_busy_fill", 64'(bus.busy), 64'd1);
    word(32'h11223344, 1'b0, 16'd0, 1'b1, 9'd0);
    word(32'h55667788, 1'b0, 16'd0, 1'b1, 9'd1);
    chk("t1_avail_pre", 64'(bus.frm_avail), 64'd0);
    word(32'h99AA0000, 1'b1, 16'd18, 1'b1, 9'd2);
    chk_frm("t1", 16'd10, 9'd3, 1'b0);
    chk("t1_busy_idle", 64'(bus.busy), 64'd0);
    expect_out(32'h11223344, 1'b0);
    expect_out(32'h55667788, 1'b0);
    expect_out(32'h99AA0000, 1'b1);
    rd_frame(3);
    chk("t1_avail_post", 64'(bus.frm_avail), 64'd0);
    chk_q("t1");

    // ping-pong with a dropped third frame
    do_reset();
    sof();
    word(32'hA0000001, 1'b0, 16'd0, 1'b1, 9'd0);
    word(32'hA0000002, 1'b1, 16'd16, 1'b1, 9'd1);
    sof();
    word(32'hB0000001, 1'b0, 16'd0, 1'b1, 9'd256);
    word(32'hB0000002, 1'b1, 16'd20, 1'b1, 9'd257);
    sof();
    chk("t2_drop_cnt", 64'(bus.drop_cnt), 64'd1);
    word(32'hC0000001, 1'b0, 16'd0, 1'b0, 9'd0);
    word(32'hC0000002, 1'b1, 16'd16, 1'b0, 9'd0);
    tick();
    chk_frm("t2a", 16'd8, 9'd2, 1'b0);
    expect_out(32'hA0000001, 1'b0);
    expect_out(32'hA0000002, 1'b1);
    rd_frame(2);
    chk_frm("t2b", 16'd12, 9'd2, 1'b0);
    expect_out(32'hB0000001, 1'b0);
    expect_out(32'hB0000002, 1'b1);
    rd_frame(2);
    chk("t2_avail_post", 64'(bus.frm_avail), 64'd0);
    chk("t2_drop_hold", 64'(bus.drop_cnt), 64'd1);
    chk_q("t2");

    // overflow: 260 words into a 256-word bank
    do_reset();
    sof();
    for (int i = 0; i < 260; i++) begin
      word(32'hD000_0000 + 32'(i), (i == 259), 16'd1048, (i < 256), 9'(i));
    end
    tick();
    chk_frm("t3", 16'd1040, 9'd256, 1'b1);
    chk_q("t3");

    // aborted frame restarts at offset 0
    do_reset();
    sof();
    word(32'hE0000001, 1'b0, 16'd0, 1'b1, 9'd0);
    word(32'hE0000002, 1'b0, 16'd0, 1'b1, 9'd1);
    sof();
    word(32'hE1000001, 1'b1, 16'd12, 1'b1, 9'd0);
    chk_frm("t4", 16'd4, 9'd1, 1'b0);
    tick();
    expect_out(32'hE1000001, 1'b1);
    rd_frame(1);
    chk_q("t4");

    // zero-length frame, then short rx_len
    do_reset();
    sof();
    bus.rx_eof = 1'b1; bus.rx_len = 16'd8;
    tick();
    bus.rx_eof = 1'b0;
    chk("t5_zero_avail", 64'(bus.frm_avail), 64'd0);
    tick();
    chk("t5_zero_busy", 64'(bus.busy), 64'd0);
    sof();
    word(32'hF0000001, 1'b1, 16'd4, 1'b1, 9'd0);
    chk_frm("t5", 16'd0, 9'd1, 1'b0);
    tick();
    chk_q("t5");

    // reset during the second streamed word of a 4-word frame
    do_reset();
    sof();
    word(32'h60000001, 1'b0, 16'd0, 1'b1, 9'd0);
    word(32'h60000002, 1'b0, 16'd0, 1'b1, 9'd1);
    word(32'h60000003, 1'b0, 16'd0, 1'b1, 9'd2);
    word(32'h60000004, 1'b1, 16'd24, 1'b1, 9'd3);
    chk_frm("t6", 16'd16, 9'd4, 1'b0);
    tick();
    expect_out(32'h60000001, 1'b0);
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    chk("t6_lat_t1", 64'(bus.out_valid), 64'd0);
    tick();
    chk("t6_lat_t2", 64'(bus.out_valid), 64'd1);
    tick();
    chk("t6_second_valid", 64'(bus.out_valid), 64'd1);
    chk("t6_second_data", 64'(bus.out_data), 64'h60000002);
    clr = 1'b0;
    #1;
    check_zero("t6_midrd");
    tick();
    tick();
    clr = 1'b1;
    tick();
    chk("t6_post_avail", 64'(bus.frm_avail), 64'd0);
    chk("t6_post_drop", 64'(bus.drop_cnt), 64'd0);
    chk("t6_post_busy", 64'(bus.busy), 64'd0);
    sof();
    word(32'h70000001, 1'b1, 16'd12, 1'b1, 9'd0);
    chk_frm("t6_new", 16'd4, 9'd1, 1'b0);
    tick();
    chk_q("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/udp_rx_pingpong_ctrl.md
Name: udp_rx_pingpong_ctrl

Overview:
- Buffer controller between the GMII UDP receiver and the downstream consumer.
- Assigns each received UDP payload to one of two RAM banks (ping-pong) and generates the write addresses.
- Tracks bank ownership and drops frames when no bank is free.
- Streams each completed frame out of RAM in arrival order on a consumer start pulse.

Parameters:
- BANK_AW, 8, word-address width of one bank (bank depth 2^BANK_AW 32-bit words).
- HDR_BYTES, 8, UDP header bytes subtracted from rx_len.

Ports:
- clk  in  1  receive clock (GMII rx clock domain).
- clr  in  1  asynchronous active-low reset.
- rx_sof  in  1  one-cycle pulse: UDP payload starts.
- rx_data  in  32  payload word, MSB-first byte packing, tail zero-padded.
- rx_valid  in  1  rx_data valid this cycle.
- rx_eof  in  1  one-cycle pulse: payload complete; may coincide with last rx_valid.
- rx_len  in  16  UDP length field (header included); sampled when rx_eof is high.
- ram_we  out  1  RAM write enable.
- ram_waddr  out  BANK_AW+1  {bank, offset}.
- ram_wdata  out  32  RAM write data.
- ram_raddr  out  BANK_AW+1  {bank, offset}.
- ram_rdata  in  32  RAM read data; 1-cycle read latency.
- frm_avail  out  1  committed frame ready to read.
- frm_bytes  out  16  payload bytes of the head frame.
- frm_words  out  BANK_AW+1  words stored for the head frame.
- frm_trunc  out  1  head frame exceeded the bank and was truncated.
- rd_start  in  1  pulse: stream the head frame.
- out_data  out  32  streamed word.
- out_valid  out  1  out_data valid.
- out_last  out  1  final word of the frame; coincident with out_valid.
- drop_cnt  out  16  frames dropped for lack of a free bank; saturates at 16'hFFFF.
- busy  out  1  write FSM or read FSM not idle.

Behaviour:
Reset (clr low, async):
- All outputs 0.
- Both banks FREE; wr_ptr = rd_ptr = 0; both FSMs idle.

Bank status:
- Each bank is FREE, FULL or READING. Status is registered and decisions use the value at the clock edge.
- Per-bank metadata: words, bytes, trunc.

Write FSM, states W_IDLE / W_FILL / W_DROP:
- W_IDLE, rx_sof:
  - If bank[wr_ptr] is FREE: offset = 0, trunc = 0, go to W_FILL.
  - Otherwise: drop_cnt increments (saturating), go to W_DROP.
- W_FILL, rx_valid:
  - If offset < 2^BANK_AW: on the next cycle ram_we = 1, ram_waddr = {wr_ptr, offset}, ram_wdata = rx_data; then offset increments.
  - Otherwise the word is discarded and trunc = 1.
- W_FILL, rx_eof (a coincident rx_valid word is written first and counted):
  - words = offset including that word; bytes = rx_len - HDR_BYTES, or 0 if rx_len < HDR_BYTES.
  - If words > 0: bank goes FULL at the next edge and wr_ptr toggles.
  - If words == 0: bank stays FREE, no commit.
  - Go to W_IDLE.
- W_FILL, rx_sof without a prior rx_eof (aborted frame): the partial frame is discarded and a new fill restarts at offset 0 in the same bank.
- W_DROP: ignore rx_valid; rx_eof returns to W_IDLE; rx_sof counts a further drop.
- Collision: rx_sof in the same cycle that the read side frees bank[wr_ptr] is treated as not free, so the frame is dropped.

Read FSM, states R_IDLE / R_READ / R_FLUSH:
- frm_avail = (R_IDLE and bank[rd_ptr] == FULL).
- While frm_avail is high, frm_bytes / frm_words / frm_trunc show bank[rd_ptr] metadata; otherwise they are 0.
- R_IDLE, rd_start with frm_avail: bank becomes READING, go to R_READ; rd_start without frm_avail is ignored.
- R_READ:
  - Issue ram_raddr = {rd_ptr, k} for k = 0 .. words-1, one per cycle.
  - out_valid is high one cycle after each address, with out_data = ram_rdata.
  - After the final address, go to R_FLUSH.
- R_FLUSH: the final word is output with out_last = 1; at that edge the bank becomes FREE, rd_ptr toggles, go to R_IDLE.
- Output is continuous, with no backpressure.
- Latency: rd_start at T gives the first out_valid at T+2.
- Commit latency: rx_eof at T gives frm_avail at T+1, if rd_ptr points at that bank.

Concurrency and reset:
- Write into one bank and read of the other run concurrently.
- A commit and a release in the same cycle on different banks are both honoured.
- clr low mid-frame or mid-read aborts everything immediately and all state returns to reset values.

Test Plan:
- Single frame: rx_sof, 3 words 0x11223344 / 0x55667788 / 0x99AA0000 with rx_eof on the 3rd, rx_len = 18 -> ram_we 3 times at addr 0,1,2; frm_avail 1 cycle after rx_eof with frm_bytes = 10, frm_words = 3; rd_start -> 3 out_valid words in order, out_last on the 3rd, frm_avail then low.
- Ping-pong: two frames of 2 words, no read -> second frame at addrs 256 and 257; a third rx_sof -> drop_cnt = 1, its words not written; read both -> bank-0 frame then bank-1 frame, frm_avail low afterwards.
- Overflow: 260 words into one bank, rx_len = 1048 -> exactly 256 writes, frm_words = 256, frm_trunc = 1, frm_bytes = 1040.
- Aborted frame: rx_sof, 2 words, rx_sof again, 1 word, rx_eof -> frm_words = 1, stored word at offset 0 equals the post-restart word.
- Zero-length and short rx_len: rx_sof then rx_eof with no words -> no commit, frm_avail stays 0; a 1-word frame with rx_len = 4 -> frm_bytes = 0.
- Reset mid-read: clr low during the 2nd out_valid of a 4-word frame -> all outputs 0 immediately; after release both banks FREE, drop_cnt = 0, frm_avail = 0.
